bus_op_sequencer: RTL and testbench
===================================

// Module: bus_op_sequencer
// PURPOSE
//   Control-side counterpart of the shared-bus ALU datapath: accepts one instruction
//   (op, rx, ry, rd) per handshake and drives the bus/register/ALU control strobes.
//   Each instruction runs as: reg[rx]->ALU A, reg[ry]->ALU B, compute, result->reg[rd].
//   Sits between the instruction source and the register file + ALU block on the 16-bit bus.
// PARAMETERS
//   NUM_REGS  4   register-file entries; one-hot reg enables, index width clog2(NUM_REGS)
//   SEL_W     4   ALU select width; op is forwarded unchanged as sel
//   DATA_W    16  bus width (immediate path only)
//   CNT_W     16  retired-instruction counter width
// PORTS
//   clk          in   1         system clock, rising edge
//   reset        in   1         asynchronous, active-low reset
//   instr_valid  in   1         instruction present
//   instr_ready  out  1         sequencer can accept this cycle
//   instr_op     in   SEL_W     ALU operation / opcode
//   instr_rx     in   RIDX      source A register index
//   instr_ry     in   RIDX      source B register index
//   instr_rd     in   RIDX      destination register index
//   reg_out_en   out  NUM_REGS  one-hot register tristate-drive enable
//   reg_in_en    out  NUM_REGS  one-hot register load enable
//   alu_a        out  1         load ALU operand A from bus
//   alu_b        out  1         load ALU operand B from bus
//   sel          out  SEL_W     ALU select
//   alu_in_en    out  1         capture ALU result register
//   alu_out_en   out  1         ALU result drives bus
//   done         out  1         1-cycle pulse, instruction retired
//   retired_cnt  out  CNT_W     retired-instruction count, wraps to 0
// BEHAVIOUR
//   Reset (async, reset==0): state IDLE; every enable, done, sel, retired_cnt = 0; latched fields = 0.
//   FSM IDLE->LD_A->LD_B->EXEC->WB->(IDLE | LD_A). Outputs decode from state reg only (no valid->output path).
//   Accept = instr_valid & instr_ready; instr_ready=1 in IDLE and WB, else 0. Fields latched on accept.
//   LD_A: reg_out_en[rx]=1, alu_a=1.  LD_B: reg_out_en[ry]=1, alu_b=1.
//   EXEC: alu_in_en=1.  WB: alu_out_en=1, reg_in_en[rd]=1, done=1, retired_cnt++ at WB exit edge.
//   sel = latched op, held stable from the cycle after accept until the next accept.
//   Latency: accept edge -> done high 4 cycles later; back-to-back throughput 1 instr / 4 cycles.
//   Accept in WB: fields relatch, next state LD_A; the WB write of the old instruction still completes.
//   rx==ry legal (same register driven twice); rd==rx/ry legal (write happens last).
//   Bus exclusivity invariant: at most one of {reg_out_en bits, alu_out_en, imm_out_en} high per cycle.
//   Reset mid-instruction: all strobes drop asynchronously; instruction discarded, count unchanged.
//   instr_valid outside IDLE/WB: ignored, nothing latched; source must hold it until ready.
// CONFIGURATION
//   SEQ_IMM_LOAD_EN defined: adds ports instr_imm (in, DATA_W), imm_bus (out, DATA_W tristate),
//     imm_out_en (out, 1). Opcode OP_LOADI (all ones) runs IDLE->IMM->IDLE|LD_A: in IMM,
//     imm_bus = latched imm, imm_out_en=1, reg_in_en[rd]=1, done=1, count++; the ALU is never
//     touched. Accept in IMM is allowed, as in WB. imm_bus is high-Z whenever imm_out_en=0.
//   Undefined: no extra ports; all-ones is an ordinary ALU sel value.
// STRUCTURE
//   Package seq_pkg: state enum (IDLE, LD_A, LD_B, EXEC, WB, IMM), OP_LOADI constant, RIDX width fn.
//   Sub-module reg_sel_decoder: index + enable -> NUM_REGS one-hot, instantiated for out and in paths.
// TESTING
//   Reset then op=4'h2,rx=1,ry=2,rd=3 -> reg_out_en 0010+alu_a, 0100+alu_b, alu_in_en, 1000 in+alu_out_en+done; cnt=1.
//   Two instructions, valid held -> second accepted in WB cycle; done pulses exactly 4 cycles apart; cnt=2.
//   Every cycle of a 200-instr random run -> bus exclusivity holds; sel constant across LD_A..WB.
//   Reset low during LD_B -> all strobes 0 same cycle; after release instr_ready=1, cnt unchanged.
//   rx=ry=rd=0 -> reg_out_en 0001 in LD_A and LD_B, reg_in_en 0001 in WB only.
//   SEQ_IMM_LOAD_EN: op=4'hF, imm=16'hBEEF, rd=2 -> next cycle imm_bus=BEEF, reg_in_en=0100, done, ALU strobes 0.
//   cnt preset near max via 2^CNT_W retirements (CNT_W=4 build) -> wraps 4'hF->4'h0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants for the bus operation sequencer: FSM state encodings,
// the immediate-load opcode and the register-index width helper.
package seq_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_LD_A = 3'd1;
  localparam logic [STATE_W-1:0] ST_LD_B = 3'd2;
  localparam logic [STATE_W-1:0] ST_EXEC = 3'd3;
  localparam logic [STATE_W-1:0] ST_WB   = 3'd4;
  localparam logic [STATE_W-1:0] ST_IMM  = 3'd5;

  localparam int unsigned OP_W = 4;

  // Opcode that selects the immediate-load path when that path is built in.
  localparam logic [OP_W-1:0] OP_LOADI = 4'hF;

  // Register index width; a single-entry file still needs one index bit.
  function automatic int unsigned ridx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Register index to one-hot enable decoder; all-zero output when disabled
// or when the index points past the last register.
module reg_sel_decoder
  import seq_pkg::*;
#(
  parameter  int unsigned NUM_REGS = 4,
  localparam int unsigned RIDX     = ridx_w(NUM_REGS)
) (
  input  logic [RIDX-1:0]     idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot_c
);

  always_comb begin
    onehot_c = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      onehot_c[i] = en && (idx == RIDX'(i));
    end
  end

endmodule

// File: rtl/bus_op_sequencer.sv
// Control sequencer for the shared-bus ALU datapath: one instruction per
// handshake, run as load A, load B, execute, write back. Define
// SEQ_IMM_LOAD_EN to add the immediate-load path (instr_imm, imm_bus, imm_out_en).
module bus_op_sequencer
  import seq_pkg::*;
#(
  parameter  int unsigned NUM_REGS = 4,
  parameter  int unsigned SEL_W    = 4,
`ifdef SEQ_IMM_LOAD_EN
  parameter  int unsigned DATA_W   = 16,
`endif
  parameter  int unsigned CNT_W    = 16,
  localparam int unsigned RIDX     = ridx_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [SEL_W-1:0]    instr_op,
  input  logic [RIDX-1:0]     instr_rx,
  input  logic [RIDX-1:0]     instr_ry,
  input  logic [RIDX-1:0]     instr_rd,
`ifdef SEQ_IMM_LOAD_EN
  input  logic [DATA_W-1:0]   instr_imm,
  output logic [DATA_W-1:0]   imm_bus,
  output logic                imm_out_en,
`endif
  output logic [NUM_REGS-1:0] reg_out_en,
  output logic [NUM_REGS-1:0] reg_in_en,
  output logic                alu_a,
  output logic                alu_b,
  output logic [SEL_W-1:0]    sel,
  output logic                alu_in_en,
  output logic                alu_out_en,
  output logic                done,
  output logic [CNT_W-1:0]    retired_cnt
);

  logic [STATE_W-1:0]  state_q;
  logic [STATE_W-1:0]  state_d;
  logic [RIDX-1:0]     rx_q;
  logic [RIDX-1:0]     ry_q;
  logic [RIDX-1:0]     rd_q;
  logic [RIDX-1:0]     rx_d;
  logic [RIDX-1:0]     ry_d;
  logic [RIDX-1:0]     rd_d;
  logic                accept_c;
  logic                loadi_c;
  logic [RIDX-1:0]     out_idx_c;
  logic                out_sel_c;
  logic                in_sel_c;
  logic [NUM_REGS-1:0] out_onehot_c;
  logic [NUM_REGS-1:0] in_onehot_c;

  assign accept_c = instr_valid && instr_ready;

`ifdef SEQ_IMM_LOAD_EN
  logic [DATA_W-1:0] imm_q;

  assign loadi_c = accept_c && (instr_op == {SEL_W{1'b1}});
  assign imm_bus = imm_out_en ? imm_q : {DATA_W{1'bz}};
`else
  assign loadi_c = 1'b0;
`endif

  // Next state; instr_ready is only high in IDLE, WB and IMM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = loadi_c ? ST_IMM : ST_LD_A;
        end
      end
      ST_LD_A: state_d = ST_LD_B;
      ST_LD_B: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB, ST_IMM: begin
        if (accept_c) begin
          state_d = loadi_c ? ST_IMM : ST_LD_A;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Field values the next cycle will see, so strobes can be registered.
  always_comb begin
    rx_d = rx_q;
    ry_d = ry_q;
    rd_d = rd_q;
    if (accept_c) begin
      rx_d = instr_rx;
      ry_d = instr_ry;
      rd_d = instr_rd;
    end
  end

  always_comb begin
    out_sel_c = (state_d == ST_LD_A) || (state_d == ST_LD_B);
    in_sel_c  = (state_d == ST_WB) || (state_d == ST_IMM);
    out_idx_c = (state_d == ST_LD_B) ? ry_d : rx_d;
  end

  reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_out_dec (
    .idx      (out_idx_c),
    .en       (out_sel_c),
    .onehot_c (out_onehot_c)
  );

  reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_in_dec (
    .idx      (rd_d),
    .en       (in_sel_c),
    .onehot_c (in_onehot_c)
  );

  // State and latched instruction fields.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rx_q    <= '0;
      ry_q    <= '0;
      rd_q    <= '0;
      sel     <= '0;
    end else begin
      state_q <= state_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      rd_q    <= rd_d;
      if (accept_c) begin
        sel <= instr_op;
      end
    end
  end

  // Control strobes, registered from the next state so they track state_q exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_ready <= 1'b1;
      reg_out_en  <= '0;
      reg_in_en   <= '0;
      alu_a       <= 1'b0;
      alu_b       <= 1'b0;
      alu_in_en   <= 1'b0;
      alu_out_en  <= 1'b0;
      done        <= 1'b0;
    end else begin
      instr_ready <= (state_d == ST_IDLE) || (state_d == ST_WB) || (state_d == ST_IMM);
      reg_out_en  <= out_onehot_c;
      reg_in_en   <= in_onehot_c;
      alu_a       <= (state_d == ST_LD_A);
      alu_b       <= (state_d == ST_LD_B);
      alu_in_en   <= (state_d == ST_EXEC);
      alu_out_en  <= (state_d == ST_WB);
      done        <= in_sel_c;
    end
  end

  // Retirement counter advances on the edge that leaves WB or IMM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_cnt <= '0;
    end else if ((state_q == ST_WB) || (state_q == ST_IMM)) begin
      retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

`ifdef SEQ_IMM_LOAD_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imm_q      <= '0;
      imm_out_en <= 1'b0;
    end else begin
      if (accept_c) begin
        imm_q <= instr_imm;
      end
      imm_out_en <= (state_d == ST_IMM);
    end
  end
`endif

endmodule

// File: tb/tb_bus_op_sequencer.sv
// Scoreboard bench for bus_op_sequencer: the stimulus side queues expected
// instruction behaviour at accept time, a negedge monitor checks the strobes.
module tb_bus_op_sequencer;
  import seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  instr_op = '0;
  logic [1:0]  instr_rx = '0;
  logic [1:0]  instr_ry = '0;
  logic [1:0]  instr_rd = '0;
  logic [15:0] instr_imm = '0;
  logic [3:0]  reg_out_en, reg_in_en;
  logic        alu_a, alu_b, alu_in_en, alu_out_en, done;
  logic [3:0]  sel;
  logic [15:0] retired_cnt;
  logic        imm_oe;

  logic        w4_ready, w4_alu_a, w4_alu_b, w4_alu_in_en, w4_alu_out_en, w4_done;
  logic [3:0]  w4_reg_out_en, w4_reg_in_en, w4_sel, w4_cnt;

  always #5 clk = ~clk;

`ifdef SEQ_IMM_LOAD_EN
  logic [15:0] imm_bus, w4_imm_bus;
  logic        w4_imm_oe;
`else
  assign imm_oe = 1'b0;
`endif

  bus_op_sequencer dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rx(instr_rx), .instr_ry(instr_ry), .instr_rd(instr_rd),
`ifdef SEQ_IMM_LOAD_EN
    .instr_imm(instr_imm), .imm_bus(imm_bus), .imm_out_en(imm_oe),
`endif
    .reg_out_en(reg_out_en), .reg_in_en(reg_in_en), .alu_a(alu_a), .alu_b(alu_b),
    .sel(sel), .alu_in_en(alu_in_en), .alu_out_en(alu_out_en), .done(done),
    .retired_cnt(retired_cnt)
  );

  // Narrow-counter instance sharing the stimulus, used for the wrap behaviour.
  bus_op_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(w4_ready),
    .instr_op(instr_op), .instr_rx(instr_rx), .instr_ry(instr_ry), .instr_rd(instr_rd),
`ifdef SEQ_IMM_LOAD_EN
    .instr_imm(instr_imm), .imm_bus(w4_imm_bus), .imm_out_en(w4_imm_oe),
`endif
    .reg_out_en(w4_reg_out_en), .reg_in_en(w4_reg_in_en), .alu_a(w4_alu_a), .alu_b(w4_alu_b),
    .sel(w4_sel), .alu_in_en(w4_alu_in_en), .alu_out_en(w4_alu_out_en), .done(w4_done),
    .retired_cnt(w4_cnt)
  );

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  rx, ry, rd;
    logic [15:0] imm;
    bit          is_imm;
    int          cnt_before;
    int          done_cycle;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   model_cnt = 0;
  bit   in_reset = 1'b1;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [3:0] onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic flag(input string name, input string act, input string req);
    checks++;
    errors++;
    $display("FAIL %s: actual %s required %s (cycle %0d)", name, act, req, cycle);
  endtask

  // Monitor: checks every cycle's strobes against the oldest queued instruction.
  always @(negedge clk) begin
    if (!in_reset) begin
      chk("bus_excl", 32'(($countones(reg_out_en) + 32'(alu_out_en) + 32'(imm_oe)) <= 1), 32'd1);
      if (sb.size() > 0 && sb[0].done_cycle < cycle) begin
        flag("done_timing", "no done", $sformatf("done at cycle %0d", sb[0].done_cycle));
        void'(sb.pop_front());
      end
      if (alu_a || alu_b || alu_in_en || done) begin
        if (sb.size() == 0) begin
          flag("spurious_strobe", "strobe active", "idle with empty queue");
        end else begin
          mon_e = sb[0];
          chk("sel_stable", 32'(sel), 32'(mon_e.op));
          if (alu_a) begin
            chk("lda_out_en", 32'(reg_out_en), 32'(onehot(mon_e.rx)));
            chk("lda_others", 32'({alu_b, alu_in_en, alu_out_en, done}), 32'd0);
            chk("lda_ready", 32'(instr_ready), 32'd0);
          end
          if (alu_b) begin
            chk("ldb_out_en", 32'(reg_out_en), 32'(onehot(mon_e.ry)));
            chk("ldb_others", 32'({alu_a, alu_in_en, alu_out_en, done}), 32'd0);
            chk("ldb_ready", 32'(instr_ready), 32'd0);
          end
          if (alu_in_en) begin
            chk("exec_out_en", 32'(reg_out_en), 32'd0);
            chk("exec_others", 32'({alu_a, alu_b, alu_out_en, done}), 32'd0);
          end
          if (done) begin
            chk("done_cycle", 32'(cycle), 32'(mon_e.done_cycle));
            chk("wb_in_en", 32'(reg_in_en), 32'(onehot(mon_e.rd)));
            chk("wb_ready", 32'(instr_ready), 32'd1);
            chk("cnt_before", 32'(retired_cnt), 32'(mon_e.cnt_before));
            chk("cnt4_before", 32'(w4_cnt), 32'(mon_e.cnt_before % 16));
            chk("wb_out_en", 32'(reg_out_en), 32'd0);
            if (mon_e.is_imm) begin
              chk("imm_alu_idle", 32'({alu_a, alu_b, alu_in_en, alu_out_en}), 32'd0);
              chk("imm_oe", 32'(imm_oe), 32'd1);
`ifdef SEQ_IMM_LOAD_EN
              chk("imm_bus", 32'(imm_bus), 32'(mon_e.imm));
`endif
            end else begin
              chk("wb_alu_out", 32'(alu_out_en), 32'd1);
              chk("wb_imm_oe", 32'(imm_oe), 32'd0);
            end
            void'(sb.pop_front());
          end
        end
      end
      if (!done) chk("no_write", 32'(reg_in_en), 32'd0);
    end
  end

  task automatic issue(input logic [3:0] op, input logic [1:0] rx, input logic [1:0] ry,
                       input logic [1:0] rd, input logic [15:0] imm, input bit hold);
    exp_t e;
    int   t;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op = op; instr_rx = rx; instr_ry = ry; instr_rd = rd; instr_imm = imm;
    t = 0;
    while (!instr_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!instr_ready) begin
      flag("accept_timeout", "ready low", "ready within 100 cycles");
      instr_valid = 1'b0;
      return;
    end
    e.op = op; e.rx = rx; e.ry = ry; e.rd = rd; e.imm = imm;
`ifdef SEQ_IMM_LOAD_EN
    e.is_imm = (op == OP_LOADI);
`else
    e.is_imm = 1'b0;
`endif
    e.cnt_before = model_cnt;
    e.done_cycle = cycle + (e.is_imm ? 1 : 4);
    sb.push_back(e);
    model_cnt++;
    @(posedge clk);
    #1;
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      flag("drain_timeout", $sformatf("%0d pending", sb.size()), "0 pending");
      sb.delete();
    end
    @(negedge clk);
    chk("cnt_final", 32'(retired_cnt), 32'(model_cnt));
    chk("cnt4_final", 32'(w4_cnt), 32'(model_cnt % 16));
  endtask

  // Called at a negedge; asserts reset between edges and checks the async drop.
  task automatic apply_reset();
    #2;
    reset = 1'b0;
    in_reset = 1'b1;
    #1;
    chk("rst_strobes", 32'({reg_out_en, reg_in_en, alu_a, alu_b, alu_in_en, alu_out_en, done, imm_oe}), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_cnt", 32'(retired_cnt), 32'd0);
    sb.delete();
    model_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(instr_ready), 32'd1);
    chk("post_rst_idle", 32'({reg_out_en, reg_in_en, alu_a, alu_b, alu_in_en, alu_out_en, done}), 32'd0);
    chk("post_rst_cnt", 32'(retired_cnt), 32'd0);
    chk("post_rst_cnt4", 32'(w4_cnt), 32'd0);
    in_reset = 1'b0;
  endtask

  initial begin
    int  t;
    bit  hold;
    @(negedge clk);
    apply_reset();

    issue(4'h2, 2'd1, 2'd2, 2'd3, 16'h0000, 1'b0);
    drain();

    issue(4'h5, 2'd0, 2'd3, 2'd1, 16'h0000, 1'b1);
    issue(4'h9, 2'd2, 2'd2, 2'd0, 16'h0000, 1'b0);
    drain();

    issue(4'h7, 2'd0, 2'd0, 2'd0, 16'h0000, 1'b0);
    drain();

    issue(4'hF, 2'd1, 2'd3, 2'd2, 16'hBEEF, 1'b1);
    issue(4'h3, 2'd3, 2'd1, 2'd1, 16'h1234, 1'b0);
    drain();

    issue(4'hA, 2'd3, 2'd0, 2'd2, 16'h0000, 1'b0);
    t = 0;
    while (!alu_b && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!alu_b) flag("ldb_wait", "alu_b low", "alu_b high within 20 cycles");
    apply_reset();
    repeat (6) @(negedge clk);
    chk("discard_cnt", 32'(retired_cnt), 32'd0);

    for (int i = 0; i < 200; i++) begin
      hold = (i < 199) && ($urandom_range(0, 1) == 1);
      issue(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 16'($urandom), hold);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
